// File: rtl/leds7_cmd_arbiter.sv
// rtl/leds7_cmd_arbiter.sv - two-requester arbiter serialising LED select/digit byte pairs
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   i_req_valid/led/digit   per-requester command (0 = UART host, 1 = local source)
//   o_req_ready             per-requester accept, combinational, at most one bit high
//   o_out_data/o_out_valid  byte stream to the indicator controller, no backpressure
//   o_busy, o_grant_id      a command pair is in flight, and which requester owns it
//   o_err_digit             one-cycle pulse when an accepted command is dropped (digit > 9)
module leds7_cmd_arbiter #(
  parameter int unsigned BYTE_GAP = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0]      i_req_valid,
  input  logic [1:0][1:0] i_req_led,
  input  logic [1:0][3:0] i_req_digit,
  output logic [1:0]      o_req_ready,
  output logic [7:0]      o_out_data,
  output logic            o_out_valid,
  output logic            o_busy,
  output logic            o_grant_id,
  output logic            o_err_digit
);
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_GAP_A, S_DATA, S_GAP_B} state_t;

  localparam bit         HAS_GAP  = (BYTE_GAP != 0);
  // Counter is loaded with BYTE_GAP-1 and the gap ends on the cycle it reads zero.
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(BYTE_GAP - 1) : 4'd0;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_grant;
  logic [3:0]  r_digit;
  logic [3:0]  r_gap;
  logic [7:0]  r_out_data;
  logic        r_busy;
  logic        r_grant;
  logic        r_err;

  logic        w_pick;
  logic        w_accept;
  logic        w_digit_ok;
  logic [1:0]  w_led;
  logic [3:0]  w_digit;

  // Round-robin between two: on contention the requester not granted last wins.
  always_comb begin
    if (&i_req_valid) w_pick = ~r_last_grant;
    else              w_pick = i_req_valid[1];
  end

  assign w_accept    = resetn && (r_state == S_IDLE) && (|i_req_valid);
  assign o_req_ready = w_accept ? (w_pick ? 2'b10 : 2'b01) : 2'b00;
  assign w_led       = i_req_led[w_pick];
  assign w_digit     = i_req_digit[w_pick];
  assign w_digit_ok  = (w_digit <= 4'd9);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_digit      <= 4'd0;
      r_gap        <= 4'd0;
      r_out_data   <= 8'h00;
      r_busy       <= 1'b0;
      r_grant      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_err   <= w_accept && !w_digit_ok;
      // Out-of-range commands still consume the turn so they cannot starve the other side.
      if (w_accept) begin
        r_last_grant <= w_pick;
        r_grant      <= w_pick;
        r_digit      <= w_digit;
      end
      if ((w_next == S_GAP_A || w_next == S_GAP_B) && (w_next != r_state)) begin
        r_gap <= GAP_LOAD;
      end else if (r_gap != 4'd0) begin
        r_gap <= r_gap - 4'd1;
      end
      // out_data is only rewritten when a byte is about to be emitted, so it holds otherwise.
      if (w_next == S_SEL) begin
        r_out_data <= {6'b111100, w_led};
      end else if (w_next == S_DATA) begin
        r_out_data <= {4'h0, r_digit};
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_digit_ok) w_next = S_SEL;
      S_SEL:   w_next = HAS_GAP ? S_GAP_A : S_DATA;
      S_GAP_A: if (r_gap == 4'd0) w_next = S_DATA;
      S_DATA:  w_next = HAS_GAP ? S_GAP_B : S_IDLE;
      S_GAP_B: if (r_gap == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs; the strobe is gated by reset so an aborted sequence emits nothing more.
  always_comb begin
    o_out_valid = resetn && ((r_state == S_SEL) || (r_state == S_DATA));
    o_out_data  = r_out_data;
    o_busy      = r_busy;
    o_grant_id  = r_grant;
    o_err_digit = r_err;
  end
endmodule

// File: tb/tb_leds7_cmd_arbiter.sv
// tb/tb_leds7_cmd_arbiter.sv - randomized scoreboard bench for leds7_cmd_arbiter
`timescale 1ns/1ps
module tb_leds7_cmd_arbiter;
  localparam int NI = 3;

  function automatic int gap_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  typedef struct packed {
    logic [1:0] led;
    logic [3:0] digit;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic [1:0]      valid [NI];
  logic [1:0][1:0] led   [NI];
  logic [1:0][3:0] digit [NI];
  logic [1:0]      ready [NI];
  logic [7:0]      odata [NI];
  logic            ovalid[NI];
  logic            obusy [NI];
  logic            ogrant[NI];
  logic            oerr  [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      leds7_cmd_arbiter #(.BYTE_GAP((g == 0) ? 1 : (g == 1) ? 0 : 3)) u_dut (
        .clk(clk), .resetn(resetn),
        .i_req_valid(valid[g]), .i_req_led(led[g]), .i_req_digit(digit[g]),
        .o_req_ready(ready[g]), .o_out_data(odata[g]), .o_out_valid(ovalid[g]),
        .o_busy(obusy[g]), .o_grant_id(ogrant[g]), .o_err_digit(oerr[g])
      );
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  // Pending commands per requester, index 2*inst+req; the head is what is presented.
  cmd_t qs[NI*2][$];

  // Reference model: a timeline of expected outputs per future cycle.
  int         mcyc;
  int         free_at[NI];
  bit         last_g [NI];
  bit         mgrant [NI];
  logic [7:0] hold   [NI];
  bit         sv[NI][32];
  logic [7:0] sd[NI][32];
  bit         sb[NI][32];
  bit         se[NI][32];
  int         m_s, m_gap;
  bit         m_acc, m_pick;
  logic [1:0] m_er;
  logic [7:0] m_wd;
  cmd_t       m_c;

  // Driver: present queue heads just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (qs[2*k+r].size() > 0) begin
          valid[k][r] = 1'b1;
          led[k][r]   = qs[2*k+r][0].led;
          digit[k][r] = qs[2*k+r][0].digit;
        end else begin
          valid[k][r] = 1'b0;
        end
      end
    end
  end

  // Scoreboard: compare every cycle at the falling edge, then apply arbitration rules.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      m_s = mcyc % 32;
      if (!resetn) begin
        total++;
        if (ready[k] !== 2'b00) begin bad++; $display("FAIL ready_in_reset inst=%0d cyc=%0d got=%b want=00", k, mcyc, ready[k]); end
        total++;
        if (ovalid[k] !== 1'b0) begin bad++; $display("FAIL valid_in_reset inst=%0d cyc=%0d got=%b want=0", k, mcyc, ovalid[k]); end
        free_at[k] = mcyc + 1; last_g[k] = 1'b1; mgrant[k] = 1'b0; hold[k] = 8'h00;
        for (int j = 0; j < 32; j++) begin sv[k][j] = 0; sb[k][j] = 0; se[k][j] = 0; end
      end else begin
        total++;
        if (ovalid[k] !== sv[k][m_s]) begin bad++; $display("FAIL out_valid inst=%0d cyc=%0d got=%b want=%b", k, mcyc, ovalid[k], sv[k][m_s]); end
        m_wd = sv[k][m_s] ? sd[k][m_s] : hold[k];
        if (sv[k][m_s]) hold[k] = sd[k][m_s];
        total++;
        if (odata[k] !== m_wd) begin bad++; $display("FAIL out_data inst=%0d cyc=%0d got=%h want=%h", k, mcyc, odata[k], m_wd); end
        total++;
        if (obusy[k] !== sb[k][m_s]) begin bad++; $display("FAIL busy inst=%0d cyc=%0d got=%b want=%b", k, mcyc, obusy[k], sb[k][m_s]); end
        total++;
        if (oerr[k] !== se[k][m_s]) begin bad++; $display("FAIL err_digit inst=%0d cyc=%0d got=%b want=%b", k, mcyc, oerr[k], se[k][m_s]); end
        total++;
        if (ogrant[k] !== mgrant[k]) begin bad++; $display("FAIL grant_id inst=%0d cyc=%0d got=%b want=%b", k, mcyc, ogrant[k], mgrant[k]); end
        m_acc  = (mcyc >= free_at[k]) && (valid[k] != 2'b00);
        m_pick = (valid[k] == 2'b11) ? !last_g[k] : valid[k][1];
        m_er   = m_acc ? (m_pick ? 2'b10 : 2'b01) : 2'b00;
        total++;
        if (ready[k] !== m_er) begin bad++; $display("FAIL req_ready inst=%0d cyc=%0d got=%b want=%b", k, mcyc, ready[k], m_er); end
        sv[k][m_s] = 0; sb[k][m_s] = 0; se[k][m_s] = 0;
        if (m_acc) begin
          m_c = qs[2*k+int'(m_pick)].pop_front();
          last_g[k] = m_pick;
          mgrant[k] = m_pick;
          if (m_c.digit <= 4'd9) begin
            m_gap = gap_of(k);
            sv[k][(mcyc+1)%32] = 1; sd[k][(mcyc+1)%32] = 8'hF0 | {6'd0, m_c.led};
            sv[k][(mcyc+2+m_gap)%32] = 1; sd[k][(mcyc+2+m_gap)%32] = {4'h0, m_c.digit};
            for (int j = 1; j <= 2 + 2*m_gap; j++) sb[k][(mcyc+j)%32] = 1;
            free_at[k] = mcyc + 3 + 2*m_gap;
          end else begin
            se[k][(mcyc+1)%32] = 1;
            free_at[k] = mcyc + 1;
          end
        end
      end
    end
    mcyc++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic wait_accept(input int k, input int r, output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (ready[k][r] === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      total++;
      if (ready[k] !== 2'b00) begin bad++; $display("FAIL rst_ready inst=%0d got=%b want=00", k, ready[k]); end
      total++;
      if ({ovalid[k], odata[k], obusy[k], ogrant[k], oerr[k]} !== 12'h000)
        begin bad++; $display("FAIL rst_outputs inst=%0d got v=%b d=%h b=%b g=%b e=%b want all zero", k, ovalid[k], odata[k], obusy[k], ogrant[k], oerr[k]); end
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    qs[0].push_back('{led: 2'd2, digit: 4'd7});
    wait_accept(0, 0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_accept got=timeout want=accept"); end
    qs[0].push_back('{led: 2'd3, digit: 4'd2});
    tick();
    total++;
    if ({ovalid[0], odata[0], obusy[0]} !== {1'b1, 8'hF2, 1'b1}) begin bad++; $display("FAIL single_t1 got v=%b d=%h b=%b want v=1 d=f2 b=1", ovalid[0], odata[0], obusy[0]); end
    tick();
    total++;
    if ({ovalid[0], odata[0], obusy[0]} !== {1'b0, 8'hF2, 1'b1}) begin bad++; $display("FAIL single_t2 got v=%b d=%h b=%b want v=0 d=f2 b=1", ovalid[0], odata[0], obusy[0]); end
    tick();
    total++;
    if ({ovalid[0], odata[0]} !== {1'b1, 8'h07}) begin bad++; $display("FAIL single_t3 got v=%b d=%h want v=1 d=07", ovalid[0], odata[0]); end
    tick();
    total++;
    if ({ovalid[0], obusy[0], ready[0]} !== {1'b0, 1'b1, 2'b00}) begin bad++; $display("FAIL single_t4 got v=%b b=%b r=%b want v=0 b=1 r=00", ovalid[0], obusy[0], ready[0]); end
    tick();
    total++;
    if ({obusy[0], ready[0]} !== {1'b0, 2'b01}) begin bad++; $display("FAIL single_t5 got b=%b r=%b want b=0 r=01", obusy[0], ready[0]); end
    repeat (8) tick();
  endtask

  task automatic test_bad_digit();
    bit ok;
    qs[1].push_back('{led: 2'd2, digit: 4'hC});
    wait_accept(0, 1, ok);
    total++;
    if (!ok || ready[0] !== 2'b10) begin bad++; $display("FAIL bad_accept got ok=%b r=%b want ok=1 r=10", ok, ready[0]); end
    tick();
    total++;
    if ({oerr[0], ovalid[0], obusy[0], ogrant[0]} !== 4'b1001) begin bad++; $display("FAIL bad_t1 got e=%b v=%b b=%b g=%b want 1 0 0 1", oerr[0], ovalid[0], obusy[0], ogrant[0]); end
    tick();
    total++;
    if ({oerr[0], ovalid[0], ready[0]} !== 4'b0000) begin bad++; $display("FAIL bad_t2 got e=%b v=%b r=%b want 0 0 00", oerr[0], ovalid[0], ready[0]); end
    qs[0].push_back('{led: 2'd1, digit: 4'd3});
    qs[1].push_back('{led: 2'd0, digit: 4'd4});
    tick();
    total++;
    if (ready[0] !== 2'b01) begin bad++; $display("FAIL bad_last_grant got r=%b want r=01", ready[0]); end
    repeat (12) tick();
  endtask

  task automatic test_gap0();
    bit ok;
    qs[2].push_back('{led: 2'd1, digit: 4'd9});
    wait_accept(1, 0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL gap0_accept got=timeout want=accept"); end
    tick();
    total++;
    if ({ovalid[1], odata[1], obusy[1]} !== {1'b1, 8'hF1, 1'b1}) begin bad++; $display("FAIL gap0_t1 got v=%b d=%h b=%b want v=1 d=f1 b=1", ovalid[1], odata[1], obusy[1]); end
    tick();
    total++;
    if ({ovalid[1], odata[1], obusy[1]} !== {1'b1, 8'h09, 1'b1}) begin bad++; $display("FAIL gap0_t2 got v=%b d=%h b=%b want v=1 d=09 b=1", ovalid[1], odata[1], obusy[1]); end
    tick();
    total++;
    if ({ovalid[1], obusy[1]} !== 2'b00) begin bad++; $display("FAIL gap0_t3 got v=%b b=%b want 0 0", ovalid[1], obusy[1]); end
  endtask

  task automatic test_withdraw();
    bit ok;
    int n;
    qs[4].push_back('{led: 2'd0, digit: 4'd3});
    wait_accept(2, 0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wd_accept got=timeout want=accept"); end
    qs[5].push_back('{led: 2'd2, digit: 4'd8});
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ovalid[2] === 1'b1) n++;
      total++;
      if (ready[2] !== 2'b00) begin bad++; $display("FAIL wd_busy_ready got=%b want=00", ready[2]); end
    end
    qs[5].delete();
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ovalid[2] === 1'b1) n++;
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL wd_bytes got=%0d want=2", n); end
  endtask

  task automatic test_both();
    logic [7:0] seen[$];
    qs[0].push_back('{led: 2'd0, digit: 4'd1});
    qs[1].push_back('{led: 2'd3, digit: 4'd5});
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ovalid[0] === 1'b1) seen.push_back(odata[0]);
    end
    total++;
    if (seen.size() != 4) begin bad++; $display("FAIL both_count got=%0d want=4", seen.size()); end
    else begin
      total++;
      if ({seen[0], seen[1], seen[2], seen[3]} !== 32'hF0_01_F3_05)
        begin bad++; $display("FAIL both_order got=%h %h %h %h want=f0 01 f3 05", seen[0], seen[1], seen[2], seen[3]); end
    end
  endtask

  task automatic test_alternate();
    int seq[$];
    bit pend;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      qs[0].push_back('{led: 2'($urandom_range(0, 3)), digit: 4'($urandom_range(0, 9))});
      qs[1].push_back('{led: 2'($urandom_range(0, 3)), digit: 4'($urandom_range(0, 9))});
    end
    pend = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (pend) seq.push_back(int'(ogrant[0]));
      pend = (ready[0] != 2'b00);
    end
    total++;
    if (seq.size() != 6) begin bad++; $display("FAIL alt_count got=%0d want=6", seq.size()); end
    for (int i = 0; i < 6 && i < seq.size(); i++) begin
      total++;
      if (seq[i] != (i % 2)) begin bad++; $display("FAIL alt_grant idx=%0d got=%0d want=%0d", i, seq[i], i % 2); end
    end
  endtask

  task automatic test_random();
    int k, r;
    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NI - 1);
        r = $urandom_range(0, 1);
        if (qs[2*k+r].size() < 3)
          qs[2*k+r].push_back('{led: 2'($urandom_range(0, 3)), digit: 4'($urandom_range(0, 11))});
      end
    end
    repeat (100) tick();
    for (int q = 0; q < NI*2; q++) begin
      total++;
      if (qs[q].size() != 0) begin bad++; $display("FAIL rand_lost queue=%0d got=%0d want=0", q, qs[q].size()); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    qs[1].push_back('{led: 2'd3, digit: 4'd6});
    wait_accept(0, 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL mid_accept got=timeout want=accept"); end
    tick();
    total++;
    if ({ovalid[0], odata[0], ogrant[0]} !== {1'b1, 8'hF3, 1'b1}) begin bad++; $display("FAIL mid_sel got v=%b d=%h g=%b want v=1 d=f3 g=1", ovalid[0], odata[0], ogrant[0]); end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    tick();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    total++;
    if ({ovalid[0], odata[0], obusy[0], ogrant[0], oerr[0]} !== 12'h000)
      begin bad++; $display("FAIL mid_reset got v=%b d=%h b=%b g=%b e=%b want all zero", ovalid[0], odata[0], obusy[0], ogrant[0], oerr[0]); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ovalid[0] === 1'b1) n++;
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL mid_no_data got=%0d want=0", n); end
  endtask

  initial begin
    resetn = 1'b0;
    mcyc = 0;
    for (int k = 0; k < NI; k++) begin
      valid[k] = 2'b00; led[k] = '0; digit[k] = '0;
      free_at[k] = 0; last_g[k] = 1'b1; mgrant[k] = 1'b0; hold[k] = 8'h00;
      for (int j = 0; j < 32; j++) begin sv[k][j] = 0; sd[k][j] = 8'h00; sb[k][j] = 0; se[k][j] = 0; end
    end
    test_reset();
    test_single();
    test_bad_digit();
    test_gap0();
    test_withdraw();
    test_both();
    test_alternate();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/leds7_cmd_arbiter.md
LEDS7_CMD_ARBITER -- requirements
Module: leds7_cmd_arbiter

Interface
REQ-001 Parameter BYTE_GAP, default 1: idle cycles (out_valid low) after each emitted byte; legal range 0..15.
REQ-002 clk  input  1  clock; all logic on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  per-requester command valid (index 0 = UART host, index 1 = local source).
REQ-005 req_led  input  2x2  per-requester target indicator, 0..3.
REQ-006 req_digit  input  2x4  per-requester digit value.
REQ-007 req_ready  output  2  per-requester accept; combinational, at most one bit high.
REQ-008 out_data  output  8  command byte to the indicator controller's uart_data input.
REQ-009 out_valid  output  1  single-cycle byte strobe to the controller's uart_data_valid input; no backpressure.
REQ-010 busy  output  1  high while a command pair is being emitted.
REQ-011 grant_id  output  1  index of the requester whose command is in flight.
REQ-012 err_digit  output  1  single-cycle pulse when an accepted command is dropped because its digit is out of range.

Function
REQ-013 FSM states: IDLE, SEL, GAP_A, DATA, GAP_B; GAP_A and GAP_B each last exactly BYTE_GAP cycles and are skipped when BYTE_GAP=0.
REQ-014 req_ready[i] is high only in IDLE, and only for the requester chosen by the arbiter in that cycle.
REQ-015 Handshake: a command is accepted on the cycle where req_valid[i] & req_ready[i]; a requester holds valid, led and digit stable until accepted.
REQ-016 Arbitration: with exactly one requester valid, that requester is chosen.
REQ-017 Arbitration: with both requesters valid, the requester not recorded in last_grant is chosen.
REQ-018 last_grant updates on every accept, including dropped commands.
REQ-019 On accept at cycle T with digit<=9, the block captures led, digit and id, sets grant_id, and enters SEL.
REQ-020 Cycle T+1 (SEL): out_valid=1, out_data=8'hF0|led.
REQ-021 Cycle T+2+BYTE_GAP (DATA): out_valid=1, out_data={4'h0,digit}.
REQ-022 The block is back in IDLE at T+3+2*BYTE_GAP; the next select byte comes no earlier than T+4+2*BYTE_GAP.
REQ-023 out_valid is low in every state except SEL and DATA.
REQ-024 out_data holds its last driven value while out_valid is low.
REQ-025 The select and data bytes of one command are never interleaved with another command's bytes.
REQ-026 busy is registered; it is high from T+1 through the last GAP_B cycle, and low in IDLE.
REQ-027 Digit >9 on accept: the command is still accepted (ready high), no bytes are emitted, and the FSM stays in IDLE.
REQ-028 Digit >9 on accept: err_digit pulses at T+1, busy stays low, and grant_id still updates.
REQ-029 Requests arriving while busy wait with ready low and are not lost, provided the requester holds valid.
REQ-030 When req_valid deasserts before accept, no command is issued.
REQ-031 The gap counter is 4 bits, is loaded on entry to GAP_A and GAP_B, and must not wrap.

Reset
REQ-032 During reset: FSM=IDLE, out_valid=0, out_data=8'h00, busy=0, grant_id=0, err_digit=0, gap counter=0, last_grant=1 (requester 0 wins the first contention).
REQ-033 Reset asserted mid-sequence aborts immediately; bytes not yet emitted are never emitted, and the captured command is discarded.
REQ-034 req_ready is 0 while resetn is low.

Verification
REQ-035 Single req0 (led=2, digit=7) held, BYTE_GAP=1, accepted at T -> out 8'hF2 at T+1, 8'h07 at T+3, busy high T+1..T+4, ready returns T+5.
REQ-036 req0 (led=0, digit=1) and req1 (led=3, digit=5) both valid from reset release -> 8'hF0, 8'h01 first, then 8'hF3, 8'h05; the pairs are never interleaved.
REQ-037 req0 and req1 held continuously for 6 commands -> grants alternate 0,1,0,1,0,1 on grant_id.
REQ-038 req1 digit=4'hC -> ready pulses for one cycle, err_digit=1 next cycle, no out_valid, last_grant=1.
REQ-039 BYTE_GAP=0 with req0 (led=1, digit=9) -> 8'hF1 at T+1, 8'h09 at T+2, idle at T+3.
REQ-040 resetn low at cycle T+2 after an accept at T (BYTE_GAP=1) -> only 8'hF?-byte seen, no data byte, all outputs at reset values next cycle.
